// File: rtl/sd_dumper.sv
// sd_dumper: packs DUMP_WORDS memory words into SD sectors and streams them to sd_writer.
// Define SD_DUMP_CHKSUM_EN to add a wrapping sum of all fetched words on chksum.
module sd_dumper #(
    parameter int unsigned SECTOR_BYTES = 512,
    parameter int unsigned DUMP_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0
) (
    input  logic        clk27mhz,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] start_sector,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    output logic        wstart,
    output logic [31:0] wsector,
    input  logic        wbusy,
    input  logic        inreq,
    output logic [7:0]  inbyte,
    input  logic        wdone,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] chksum
);
    localparam int unsigned SW = SECTOR_BYTES / 4;
    localparam int AW = SW > 1 ? $clog2(SW) : 1;
    localparam int FW = $clog2(SW + 1);
    localparam int BW = $clog2(SECTOR_BYTES + 1);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_PAD    = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_STREAM = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;
    localparam logic [2:0] S_FIN    = 3'd6;

    logic [2:0]    state;
    logic [31:0]   word_cnt;
    logic [FW-1:0] fill_idx;
    logic [BW-1:0] byte_idx;
    logic [31:0]   sector_ram [SW];
    logic [31:0]   rd_word;
    logic          ack, pad_wr, fill_last, at_end;

    assign ack       = state == S_FILL && mem_req && mem_ack;
    assign pad_wr    = state == S_PAD && fill_idx != FW'(SW);
    assign fill_last = fill_idx == FW'(SW - 1) || word_cnt + 32'd1 == DUMP_WORDS;
    assign at_end    = byte_idx == BW'(SECTOR_BYTES);

    always_ff @(posedge clk27mhz)
        if (ack || pad_wr) sector_ram[fill_idx[AW-1:0]] <= ack ? mem_data : 32'h0;

    // Past the end of the sector the writer gets zero fill instead of stale buffer data.
    assign rd_word = sector_ram[byte_idx[AW+1:2]];
    assign inbyte  = (state == S_STREAM && !at_end) ? rd_word[{byte_idx[1:0], 3'b000} +: 8] : 8'h00;

    always_ff @(posedge clk27mhz or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= 32'h0;
            wstart   <= 1'b0;
            wsector  <= 32'h0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            word_cnt <= 32'h0;
            fill_idx <= '0;
            byte_idx <= '0;
        end else begin
            wstart <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    wsector  <= start_sector;
                    busy     <= 1'b1;
                    done     <= 1'b0;
                    err      <= 1'b0;
                    word_cnt <= 32'h0;
                    fill_idx <= '0;
                    mem_req  <= DUMP_WORDS != 0;
                    mem_addr <= BASE_ADDR;
                    state    <= DUMP_WORDS != 0 ? S_FILL : S_FIN;
                end
                S_FILL: if (ack) begin
                    mem_req  <= 1'b0;
                    word_cnt <= word_cnt + 32'd1;
                    fill_idx <= fill_idx + 1'b1;
                    state    <= fill_last ? S_PAD : S_FILL;
                end else if (!mem_req) begin
                    mem_req  <= 1'b1;
                    mem_addr <= BASE_ADDR + {word_cnt[29:0], 2'b00};
                end
                S_PAD: if (fill_idx == FW'(SW)) state <= S_WAIT;
                       else fill_idx <= fill_idx + 1'b1;
                S_WAIT: if (!wbusy) begin
                    wstart   <= 1'b1;
                    byte_idx <= '0;
                    state    <= S_STREAM;
                end
                S_STREAM: if (wdone) begin
                    err   <= err | !at_end;
                    state <= S_NEXT;
                end else if (inreq && !at_end) byte_idx <= byte_idx + 1'b1;
                S_NEXT: begin
                    wsector  <= wsector + 32'd1;
                    fill_idx <= '0;
                    state    <= word_cnt < DUMP_WORDS ? S_FILL : S_FIN;
                end
                S_FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SD_DUMP_CHKSUM_EN
    always_ff @(posedge clk27mhz or posedge reset)
        if (reset) chksum <= 32'h0;
        else if (state == S_IDLE && start) chksum <= 32'h0;
        else if (ack) chksum <= chksum + mem_data;
`else
    assign chksum = 32'h0;
`endif
endmodule

// File: tb/tb_sd_dumper.sv
// tb_sd_dumper: scoreboard bench with memory and sd_writer models for sd_dumper.
module tb_sd_dumper;
    localparam int SB = 512;
    localparam int NW = 130;
    localparam int WPS = SB / 4;
    localparam int NSEC = (NW * 4 + SB - 1) / SB;
    localparam logic [31:0] BASE = 32'h1000;

    logic clk27mhz = 0, reset = 1, start = 0, mem_ack = 0, wbusy = 0, inreq = 0, wdone = 0;
    logic [31:0] start_sector = 0, mem_data = 0;
    logic mem_req, wstart, busy, done, err;
    logic [31:0] mem_addr, wsector, chksum;
    logic [7:0] inbyte;

    int checks = 0, failures = 0;
    logic [7:0] exp_q[$];
    logic [31:0] sec_q[$];
    int ack_delay = 0, wr_limit = SB, pat = 0;
    int rd_idx = 0, wait_cnt = 0, sec_words = 0, wstart_cnt = 0, nbytes = 0;
    logic [31:0] sum_model = 0, cur_sec = 0;
    logic [7:0] smp_exp;
    bit wr_active = 0, smp_ok;

    sd_dumper #(.SECTOR_BYTES(SB), .DUMP_WORDS(NW), .BASE_ADDR(BASE)) dut (
        .clk27mhz(clk27mhz), .reset(reset), .start(start), .start_sector(start_sector),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .wstart(wstart), .wsector(wsector), .wbusy(wbusy), .inreq(inreq), .inbyte(inbyte),
        .wdone(wdone), .busy(busy), .done(done), .err(err), .chksum(chksum)
    );

    always #5 clk27mhz = ~clk27mhz;

    function automatic logic [31:0] word_of(input int n);
        return pat == 1 ? (32'(n) * 32'h0101_0101) ^ 32'hA5C3_0F1E : 32'(n);
    endfunction

    function automatic logic [31:0] exp_chk();
`ifdef SD_DUMP_CHKSUM_EN
        return sum_model;
`else
        return 32'h0;
`endif
    endfunction

    // Memory: acks after ack_delay wait cycles, pushes the expected sector image.
    initial forever begin
        @(posedge clk27mhz); #1;
        if (reset) begin
            mem_ack = 0;
            wait_cnt = 0;
        end else if (mem_ack) mem_ack = 0;
        else if (mem_req) begin
            checks++;
            if (rd_idx >= NW || mem_addr !== BASE + 32'(rd_idx * 4)) begin
                failures++;
                $display("FAIL mem_addr idx=%0d got=%h exp=%h", rd_idx, mem_addr, BASE + 32'(rd_idx * 4));
            end
            if (wait_cnt < ack_delay) wait_cnt++;
            else begin
                wait_cnt = 0;
                mem_ack = 1;
                mem_data = word_of(rd_idx);
                sum_model += mem_data;
                for (int j = 0; j < 4; j++) exp_q.push_back(mem_data[8*j +: 8]);
                rd_idx++;
                sec_words++;
                if (sec_words == WPS || rd_idx == NW) begin
                    repeat (SB - 4 * sec_words) exp_q.push_back(8'h00);
                    sec_words = 0;
                end
            end
        end else if (wait_cnt != 0) begin
            checks++;
            failures++;
            $display("FAIL mem_req_dropped idx=%0d got=0 exp=1", rd_idx);
            wait_cnt = 0;
        end
    end

    // sd_writer: accepts wstart, requests wr_limit bytes with random gaps, then wdone.
    initial forever begin
        @(posedge clk27mhz); #1;
        inreq = 0;
        wdone = 0;
        if (reset) begin
            wr_active = 0;
            wbusy = 0;
        end else if (!wr_active) begin
            if (wstart) begin
                wstart_cnt++;
                cur_sec = sec_q.size() != 0 ? sec_q.pop_front() : 32'hDEAD_BEEF;
                checks++;
                if (wsector !== cur_sec) begin
                    failures++;
                    $display("FAIL wsector got=%0d exp=%0d", wsector, cur_sec);
                end
                wr_active = 1;
                wbusy = 1;
                nbytes = 0;
            end
        end else begin
            checks++;
            if (wstart !== 1'b0 || wsector !== cur_sec) begin
                failures++;
                $display("FAIL wstart_hold wstart=%b wsector=%0d exp_sector=%0d", wstart, wsector, cur_sec);
            end
            if (nbytes < wr_limit) inreq = $urandom_range(0, 3) != 0;
            else begin
                wdone = 1;
                wbusy = 0;
                wr_active = 0;
                while (nbytes < SB && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    nbytes++;
                end
            end
        end
    end

    always @(negedge clk27mhz) if (inreq) begin
        checks++;
        smp_ok = 1;
        smp_exp = 8'h00;
        if (nbytes < SB) begin
            if (exp_q.size() == 0) smp_ok = 0;
            else smp_exp = exp_q.pop_front();
        end
        if (!smp_ok || inbyte !== smp_exp) begin
            failures++;
            $display("FAIL inbyte sector=%0d idx=%0d got=%h exp=%h queued=%0b", cur_sec, nbytes, inbyte, smp_exp, smp_ok);
        end
        nbytes++;
    end

    task automatic prep(input int lim, input int dly, input int p);
        exp_q.delete();
        sec_q.delete();
        rd_idx = 0;
        sec_words = 0;
        wstart_cnt = 0;
        sum_model = 0;
        wr_limit = lim;
        ack_delay = dly;
        pat = p;
    endtask

    task automatic kick(input logic [31:0] s);
        for (int i = 0; i < NSEC; i++) sec_q.push_back(s + 32'(i));
        @(posedge clk27mhz); #1;
        start = 1;
        start_sector = s;
        @(posedge clk27mhz); #1;
        start = 0;
    endtask

    task automatic wait_done(output bit to);
        int n = 0;
        while (!done && n < 20000) begin
            @(posedge clk27mhz); #1;
            n++;
        end
        to = !done;
    endtask

    task automatic test_reset;
        reset = 1;
        repeat (3) @(posedge clk27mhz);
        #1;
        checks++;
        if ({mem_req, wstart, busy, done, err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000", {mem_req, wstart, busy, done, err});
        end
        checks++;
        if (mem_addr !== 0 || wsector !== 0 || inbyte !== 0) begin
            failures++;
            $display("FAIL reset_values addr=%h sector=%h inbyte=%h exp=0", mem_addr, wsector, inbyte);
        end
        checks++;
        if (chksum !== 0) begin
            failures++;
            $display("FAIL reset_chksum got=%h exp=0", chksum);
        end
        @(negedge clk27mhz);
        reset = 0;
    endtask

    task automatic test_basic;
        bit to;
        prep(SB, 0, 0);
        kick(100);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== BASE) begin
            failures++;
            $display("FAIL start_latency req=%b addr=%h exp=1/%h", mem_req, mem_addr, BASE);
        end
        checks++;
        if ({busy, done, err} !== 3'b100) begin
            failures++;
            $display("FAIL start_flags got=%b exp=100", {busy, done, err});
        end
        repeat (20) @(posedge clk27mhz);
        #1;
        start = 1;
        start_sector = 999;
        @(posedge clk27mhz); #1;
        start = 0;
        wait_done(to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL basic_timeout done=%b exp=1", done);
        end
        checks++;
        if (wstart_cnt !== NSEC || err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_end wstarts=%0d err=%b busy=%b exp=%0d/0/0", wstart_cnt, err, busy, NSEC);
        end
        checks++;
        if (exp_q.size() != 0 || sec_q.size() != 0) begin
            failures++;
            $display("FAIL basic_drain bytes=%0d sectors=%0d exp=0/0", exp_q.size(), sec_q.size());
        end
        checks++;
        if (chksum !== exp_chk()) begin
            failures++;
            $display("FAIL basic_chksum got=%h exp=%h", chksum, exp_chk());
        end
    endtask

    task automatic test_ack_delay;
        bit to;
        prep(SB, 5, 1);
        kick(7);
        wait_done(to);
        checks++;
        if (to || wstart_cnt !== NSEC || err !== 1'b0) begin
            failures++;
            $display("FAIL delay_end timeout=%b wstarts=%0d err=%b exp=0/%0d/0", to, wstart_cnt, err, NSEC);
        end
        checks++;
        if (exp_q.size() != 0 || chksum !== exp_chk()) begin
            failures++;
            $display("FAIL delay_drain bytes=%0d chksum=%h exp=0/%h", exp_q.size(), chksum, exp_chk());
        end
    endtask

    task automatic test_underrun;
        bit to;
        prep(300, 0, 1);
        kick(20);
        wait_done(to);
        checks++;
        if (to || {done, err} !== 2'b11 || wstart_cnt !== NSEC) begin
            failures++;
            $display("FAIL underrun timeout=%b done_err=%b wstarts=%0d exp=0/11/%0d", to, {done, err}, wstart_cnt, NSEC);
        end
        checks++;
        if (chksum !== exp_chk()) begin
            failures++;
            $display("FAIL underrun_chksum got=%h exp=%h", chksum, exp_chk());
        end
        prep(SB + 2, 1, 0);
        kick(30);
        checks++;
        if ({done, err} !== 2'b00) begin
            failures++;
            $display("FAIL err_clear got=%b exp=00", {done, err});
        end
        wait_done(to);
        checks++;
        if (to || err !== 1'b0 || wstart_cnt !== NSEC || exp_q.size() != 0) begin
            failures++;
            $display("FAIL overrun_end timeout=%b err=%b wstarts=%0d bytes=%0d exp=0/0/%0d/0", to, err, wstart_cnt, exp_q.size(), NSEC);
        end
    endtask

    task automatic test_reset_mid;
        bit to;
        int n = 0;
        prep(SB, 0, 0);
        kick(40);
        while (!(wr_active && nbytes >= 50) && n < 5000) begin
            @(posedge clk27mhz);
            n++;
        end
        checks++;
        if (!wr_active || wstart_cnt != 1) begin
            failures++;
            $display("FAIL mid_stream_reach active=%b wstarts=%0d exp=1/1", wr_active, wstart_cnt);
        end
        @(negedge clk27mhz); #1;
        reset = 1;
        #1;
        checks++;
        if ({mem_req, wstart, busy, done, err} !== 5'b0 || mem_addr !== 0 || wsector !== 0 || inbyte !== 0 || chksum !== 0) begin
            failures++;
            $display("FAIL mid_reset flags=%b addr=%h sector=%h inbyte=%h chksum=%h exp=0", {mem_req, wstart, busy, done, err}, mem_addr, wsector, inbyte, chksum);
        end
        repeat (2) @(posedge clk27mhz);
        @(negedge clk27mhz);
        reset = 0;
        prep(SB, 0, 1);
        kick(5);
        wait_done(to);
        checks++;
        if (to || err !== 1'b0 || wstart_cnt !== NSEC || exp_q.size() != 0 || sec_q.size() != 0) begin
            failures++;
            $display("FAIL restart_end timeout=%b err=%b wstarts=%0d bytes=%0d sectors=%0d exp=0/0/%0d/0/0", to, err, wstart_cnt, exp_q.size(), sec_q.size(), NSEC);
        end
        checks++;
        if (chksum !== exp_chk()) begin
            failures++;
            $display("FAIL restart_chksum got=%h exp=%h", chksum, exp_chk());
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_ack_delay();
        test_underrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
